// File: rtl/mw_seq.sv
// rtl/mw_seq.sv - 16-bit operation sequencer built on an external 8-bit combinational ALU
//
// Purpose: accepts one 16-bit op in IDLE, runs it as two 8-bit word passes
// (W0, W1) through the external ALU, then presents the result for one cycle (FIN).
// Optional feature macro: MW_SEQ_SUB_EN enables kSUB (issued to the ALU as kADD
// with inverted B and carry-in 1). Without it kSUB is treated as unsupported.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   START, OP_IN, A, B, CIN   request strobe, op code, operands, carry/shift-in
//   READY, DONE         idle/accepting, one-cycle result strobe
//   RESULT, CARRY, ZERO16     held result of the last completed op
//   ALU_A, ALU_B, ALU_OP, ALU_SC_IN    word slice driven to the ALU
//   ALU_OUT, ALU_SC_OUT, ALU_ZERO      ALU response for the current slice

package mw_seq_pkg;
  localparam logic [2:0] kADD = 3'd0;
  localparam logic [2:0] kSUB = 3'd1;
  localparam logic [2:0] kAND = 3'd2;
  localparam logic [2:0] kLSH = 3'd3;
  localparam logic [2:0] kRSH = 3'd4;
endpackage

module mw_seq
  import mw_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  OP_IN,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CIN,
  output logic        READY,
  output logic        DONE,
  output logic [15:0] RESULT,
  output logic        CARRY,
  output logic        ZERO16,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [2:0]  ALU_OP,
  output logic        ALU_SC_IN,
  input  logic [7:0]  ALU_OUT,
  input  logic        ALU_SC_OUT,
  input  logic        ALU_ZERO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_W0   = 2'd1;
  localparam logic [1:0] S_W1   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

`ifdef MW_SEQ_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic        cin_q;
  logic [7:0]  w0_out_q;
  logic        w0_sc_q, w0_zero_q;
  logic [15:0] result_q;
  logic        carry_q, zero_q;

  logic is_add, is_sub, is_and, is_lsh, is_rsh;
  logic supported, add_like, chained;
  logic in_w0, in_w1;
  logic a_hi_sel;
  logic [15:0] b_eff;
  logic [15:0] fin_result;
  logic        fin_carry, fin_zero;

  assign is_add    = (op_q == kADD);
  assign is_sub    = SUB_EN && (op_q == kSUB);
  assign is_and    = (op_q == kAND);
  assign is_lsh    = (op_q == kLSH);
  assign is_rsh    = (op_q == kRSH);
  assign add_like  = is_add | is_sub;
  assign chained   = add_like | is_lsh | is_rsh;   // ops whose W1 takes W0's carry/shift-out
  assign supported = add_like | is_and | is_lsh | is_rsh;

  assign in_w0 = (state_q == S_W0);
  assign in_w1 = (state_q == S_W1);

  // Right shift walks high byte first so the shifted-out bit flows downward.
  assign a_hi_sel = is_rsh ? in_w0 : in_w1;
  assign b_eff    = is_sub ? ~b_q : b_q;

  always_comb begin
    ALU_A     = 8'h00;
    ALU_B     = 8'h00;
    ALU_SC_IN = 1'b0;
    ALU_OP    = op_q;
    if ((in_w0 || in_w1) && supported) begin
      if (is_sub) begin
        ALU_OP = kADD;
      end
      ALU_A = a_hi_sel ? a_q[15:8] : a_q[7:0];
      if (add_like || is_and) begin
        ALU_B = in_w1 ? b_eff[15:8] : b_eff[7:0];
      end
      if (chained) begin
        if (in_w0) begin
          ALU_SC_IN = is_sub ? 1'b1 : cin_q;
        end else begin
          ALU_SC_IN = w0_sc_q;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_W0;
      S_W0:    state_d = S_W1;
      S_W1:    state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Result assembly at the end of W1: W0's registered word plus the live ALU word.
  always_comb begin
    fin_result = 16'h0000;
    fin_carry  = 1'b0;
    fin_zero   = 1'b1;
    if (supported) begin
      fin_result = is_rsh ? {w0_out_q, ALU_OUT} : {ALU_OUT, w0_out_q};
      fin_carry  = chained & ALU_SC_OUT;
      fin_zero   = w0_zero_q & ALU_ZERO;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      cin_q     <= 1'b0;
      w0_out_q  <= 8'h00;
      w0_sc_q   <= 1'b0;
      w0_zero_q <= 1'b0;
      result_q  <= 16'h0000;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && START) begin
        op_q  <= OP_IN;
        a_q   <= A;
        b_q   <= B;
        cin_q <= CIN;
      end
      if (in_w0) begin
        w0_out_q  <= ALU_OUT;
        w0_sc_q   <= ALU_SC_OUT;
        w0_zero_q <= ALU_ZERO;
      end
      if (in_w1) begin
        result_q <= fin_result;
        carry_q  <= fin_carry;
        zero_q   <= fin_zero;
      end
    end
  end

  assign READY  = (state_q == S_IDLE);
  assign DONE   = (state_q == S_FIN);
  assign RESULT = result_q;
  assign CARRY  = carry_q;
  assign ZERO16 = zero_q;

endmodule

// File: doc/mw_seq.md
MW_SEQ -- requirements
Module: mw_seq

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, all state on rising edge.
REQ-002 SHALL have port: RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: START in 1 request strobe; OP_IN in 3 op code (definitions package mnemonics); A, B in 16 operands; CIN in 1 carry/shift-in.
REQ-004 SHALL have ports: READY out 1 idle/accepting; DONE out 1 one-cycle result strobe; RESULT out 16; CARRY out 1; ZERO16 out 1.
REQ-005 SHALL have ALU-side ports: ALU_A, ALU_B out 8; ALU_OP out 3; ALU_SC_IN out 1; ALU_OUT in 8; ALU_SC_OUT in 1; ALU_ZERO in 1 (driven by the 8-bit combinational ALU).

Function
REQ-006 SHALL implement FSM IDLE -> W0 -> W1 -> FIN -> IDLE, one state per clock.
REQ-007 SHALL accept START only in IDLE (READY=1); SHALL capture OP_IN, A, B, CIN on that edge; START in any other state is ignored.
REQ-008 READY SHALL be 1 only in IDLE; DONE SHALL be 1 only in FIN, so DONE is high exactly 3 clocks after the accepting edge.
REQ-009 In W0/W1 the block SHALL drive one 8-bit word slice to the ALU and register ALU_OUT, ALU_SC_OUT, ALU_ZERO at the end of that cycle.
REQ-010 kADD: W0 = low bytes, ALU_SC_IN=CIN; W1 = high bytes, ALU_SC_IN = W0 carry; CARRY = W1 ALU_SC_OUT.
REQ-011 kLSH: W0 = low byte of A, ALU_SC_IN=CIN; W1 = high byte, ALU_SC_IN = W0 ALU_SC_OUT; CARRY = W1 ALU_SC_OUT (old bit 15).
REQ-012 kRSH: W0 = high byte of A, ALU_SC_IN=CIN; W1 = low byte, ALU_SC_IN = W0 ALU_SC_OUT; CARRY = W1 ALU_SC_OUT (old bit 0).
REQ-013 kAND: W0 low, W1 high, ALU_SC_IN=0; CARRY=0.
REQ-014 Unsupported OP_IN SHALL still traverse W0/W1/FIN with ALU_OP = captured code, ALU inputs 0, RESULT=0, CARRY=0, ZERO16=1.
REQ-015 ZERO16 SHALL equal AND of the registered ALU_ZERO from W0 and W1.
REQ-016 Outside W0/W1, ALU_A, ALU_B, ALU_SC_IN SHALL be 0 and ALU_OP SHALL hold the captured op.
REQ-017 RESULT, CARRY, ZERO16 SHALL update only on entry to FIN and hold until the next FIN or reset.
REQ-018 START asserted in FIN SHALL be ignored; a START in the IDLE cycle following FIN is accepted (back-to-back throughput 1 op per 4 clocks).

Reset
REQ-019 RESET SHALL force IDLE; READY=1, DONE=0, RESULT=0, CARRY=0, ZERO16=0, captured registers cleared.
REQ-020 RESET asserted in W0, W1 or FIN SHALL abort the op: no DONE, results cleared, next cycle IDLE; RESET dominates a simultaneous START.

Configuration
REQ-021 Macro MW_SEQ_SUB_EN defined: kSUB SHALL be issued to the ALU as kADD with ALU_B = ~B slice, W0 ALU_SC_IN=1, W1 ALU_SC_IN = W0 carry; CARRY = 1 means no borrow; CIN ignored.
REQ-022 MW_SEQ_SUB_EN undefined: kSUB SHALL be treated as unsupported per REQ-014.

Verification
REQ-023 kADD A=0x00FF B=0x0001 CIN=0 -> RESULT=0x0100, CARRY=0, ZERO16=0, DONE 3 clocks after accept.
REQ-024 kADD A=0xFFFF B=0x0001 CIN=0 -> RESULT=0x0000, CARRY=1, ZERO16=1.
REQ-025 kLSH A=0x80C3 CIN=1 -> RESULT=0x0187, CARRY=1; kRSH A=0x0181 CIN=0 -> RESULT=0x00C0, CARRY=1.
REQ-026 kSUB A=0x1000 B=0x0001 -> with MW_SEQ_SUB_EN RESULT=0x0FFF, CARRY=1; without it RESULT=0x0000, CARRY=0, ZERO16=1.
REQ-027 START pulsed again in W0 and FIN -> ignored, exactly one DONE; START in following IDLE -> accepted.
REQ-028 RESET asserted in W1 -> no DONE, RESULT=0, READY=1 next cycle, next START completes normally.
